// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder for the core's load/store port: one request at a time,
// a programmable number of wait cycles, then commit and a single-cycle listo/error response.
module data_mem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] direccion,
   input  logic [31:0] palabra,
   input  logic        leer,
   input  logic        escribir,
   output logic [31:0] leer_dato,
   output logic        listo,
   output logic        error,
   output logic        ocupado
);
   localparam int         DEPTH    = 2 ** ADDR_BITS;
   localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                state_r, state_nx_s;
   logic [3:0]            cnt_r, cnt_nx_s;
   logic [ADDR_BITS-1:0]  idx_r;
   logic [31:0]           data_r;
   logic                  we_r, err_r;
   logic [31:0]           leer_dato_r;
   logic                  listo_r, error_r, ocupado_r;
   logic [31:0]           mem_r [DEPTH];

   logic                  req_s, req_err_s, commit_s, mem_we_s;
   logic [ADDR_BITS-1:0]  com_idx_s;
   logic [31:0]           com_data_s;
   logic                  com_we_s, com_err_s;
   logic                  listo_nx_s, error_nx_s, ocupado_nx_s;

   function automatic logic req_error(input logic [31:0] a, input logic rd, input logic wr);
      return (a[1:0] != 2'b00) || (a[31:ADDR_BITS+2] != {(30-ADDR_BITS){1'b0}}) || (rd && wr);
   endfunction

   assign req_s     = leer | escribir;
   assign req_err_s = req_error(direccion, leer, escribir);

   // Commit operands: live inputs for the zero-latency commit taken from IDLE, captured request otherwise
   always_comb begin
      com_idx_s  = idx_r;
      com_data_s = data_r;
      com_we_s   = we_r;
      com_err_s  = err_r;
      if (state_r == ST_IDLE) begin
         com_idx_s  = direccion[ADDR_BITS+1:2];
         com_data_s = palabra;
         com_we_s   = escribir;
         com_err_s  = req_err_s;
      end else begin
         com_idx_s  = idx_r;
         com_data_s = data_r;
         com_we_s   = we_r;
         com_err_s  = err_r;
      end
   end

   // Next-state and wait counter
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      commit_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_s) begin
               if (LATENCY == 0) begin
                  state_nx_s = ST_RESP;
                  cnt_nx_s   = 4'd0;
                  commit_s   = 1'b1;
               end else begin
                  state_nx_s = ST_WAIT;
                  cnt_nx_s   = CNT_LOAD;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_nx_s = ST_RESP;
               commit_s   = 1'b1;
            end else begin
               cnt_nx_s = cnt_r - 4'd1;
            end
         end
         ST_RESP: state_nx_s = ST_IDLE;
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = 4'd0;
         end
      endcase
   end

   // Output decode from the next state so that every output leaves a flop
   always_comb begin
      listo_nx_s   = (state_nx_s == ST_RESP);
      error_nx_s   = (state_nx_s == ST_RESP) && com_err_s;
      ocupado_nx_s = (state_nx_s != ST_IDLE);
   end

   // A write must never land while reset is held, even if a request is presented then
   assign mem_we_s = commit_s && !com_err_s && com_we_s && !rst;

   // State, captured request and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         idx_r       <= {ADDR_BITS{1'b0}};
         data_r      <= 32'h0;
         we_r        <= 1'b0;
         err_r       <= 1'b0;
         leer_dato_r <= 32'h0;
         listo_r     <= 1'b0;
         error_r     <= 1'b0;
         ocupado_r   <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         if ((state_r == ST_IDLE) && req_s) begin
            idx_r  <= direccion[ADDR_BITS+1:2];
            data_r <= palabra;
            we_r   <= escribir;
            err_r  <= req_err_s;
         end
         if (commit_s && !com_err_s && !com_we_s) begin
            leer_dato_r <= mem_r[com_idx_s];
         end
         listo_r   <= listo_nx_s;
         error_r   <= error_nx_s;
         ocupado_r <= ocupado_nx_s;
      end
   end

   // Storage array; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[com_idx_s] <= com_data_s;
      end
   end

   assign leer_dato = leer_dato_r;
   assign listo     = listo_r;
   assign error     = error_r;
   assign ocupado   = ocupado_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance checked
// against a word-array reference model of request/response behaviour.
module tb_data_mem_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] direccion, palabra;
   logic        leer_t, escribir_t;
   int          sel;

   logic        leer_a, escribir_a, leer_b, escribir_b;
   logic [31:0] leer_dato_a, leer_dato_b;
   logic        listo_a, listo_b, error_a, error_b, ocupado_a, ocupado_b;

   assign leer_a     = leer_t & (sel == 0);
   assign escribir_a = escribir_t & (sel == 0);
   assign leer_b     = leer_t & (sel == 1);
   assign escribir_b = escribir_t & (sel == 1);

   logic [31:0] ob_dato;
   logic        ob_listo, ob_error, ob_ocupado;
   assign ob_dato    = (sel == 0) ? leer_dato_a : leer_dato_b;
   assign ob_listo   = (sel == 0) ? listo_a : listo_b;
   assign ob_error   = (sel == 0) ? error_a : error_b;
   assign ob_ocupado = (sel == 0) ? ocupado_a : ocupado_b;

   data_mem_responder #(.ADDR_BITS(8), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .direccion(direccion), .palabra(palabra),
      .leer(leer_a), .escribir(escribir_a), .leer_dato(leer_dato_a),
      .listo(listo_a), .error(error_a), .ocupado(ocupado_a)
   );

   data_mem_responder #(.ADDR_BITS(8), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .direccion(direccion), .palabra(palabra),
      .leer(leer_b), .escribir(escribir_b), .leer_dato(leer_dato_b),
      .listo(listo_b), .error(error_b), .ocupado(ocupado_b)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_mem   [2][256];
   bit          model_valid [2][256];
   logic [31:0] exp_rd [2];
   bit          exp_known [2];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_err(input logic [31:0] a, input bit rd, input bit wr);
      return (a % 32'd4 != 32'd0) || (a >= 32'd1024) || (rd && wr);
   endfunction

   function automatic int lat_of(input int s);
      return (s == 0) ? 2 : 0;
   endfunction

   task automatic model_commit(input int s, input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] d);
      if (!exp_err(a, rd, wr)) begin
         if (wr) begin
            model_mem[s][a / 32'd4]   = d;
            model_valid[s][a / 32'd4] = 1'b1;
         end else begin
            exp_rd[s]    = model_mem[s][a / 32'd4];
            exp_known[s] = model_valid[s][a / 32'd4];
         end
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         exp_rd[s]    = 32'h0;
         exp_known[s] = 1'b1;
      end
   endtask

   task automatic do_req(input int s, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
      int k;
      @(negedge clk);
      sel = s; leer_t = rd; escribir_t = wr; direccion = a; palabra = d;
      @(posedge clk);
      @(negedge clk);
      leer_t = 1'b0; escribir_t = 1'b0;
      check_eq("busy_after_sample", ob_ocupado, 32'd1);
      k = 1;
      while (ob_listo !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check_eq("latency", k, lat_of(s) + 1);
      check_eq("error", ob_error, exp_err(a, rd, wr));
      model_commit(s, rd, wr, a, d);
      if (exp_known[s]) check_eq("leer_dato", ob_dato, exp_rd[s]);
      @(negedge clk);
      check_eq("listo_one_cycle", ob_listo, 32'd0);
      check_eq("error_one_cycle", ob_error, 32'd0);
      check_eq("idle_after_resp", ob_ocupado, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int k;
      logic [31:0] a;
      bit rd, wr;
      rst = 1'b1; sel = 0; leer_t = 1'b0; escribir_t = 1'b0;
      direccion = 32'h0; palabra = 32'h0;
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 256; i++) model_valid[s][i] = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_leer_dato_a", leer_dato_a, 32'h0);
      check_eq("rst_listo_a", listo_a, 32'd0);
      check_eq("rst_error_a", error_a, 32'd0);
      check_eq("rst_ocupado_a", ocupado_a, 32'd0);
      check_eq("rst_leer_dato_b", leer_dato_b, 32'h0);
      check_eq("rst_ocupado_b", ocupado_b, 32'd0);
      rst = 1'b0;

      // directed write/read, misaligned, out of range
      do_req(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF);
      do_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
      check_eq("read_back_10", ob_dato, 32'hDEADBEEF);
      do_req(0, 1'b0, 1'b1, 32'h0000_0012, 32'h12345678);
      do_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
      check_eq("misaligned_no_write", ob_dato, 32'hDEADBEEF);
      do_req(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
      check_eq("out_of_range_hold", ob_dato, 32'hDEADBEEF);
      do_req(0, 1'b1, 1'b1, 32'h0000_0010, 32'h0);

      // strobe held continuously: re-sampled every LATENCY+2 cycles
      p = lat_of(0) + 2;
      @(negedge clk);
      sel = 0; leer_t = 1'b1; escribir_t = 1'b0; direccion = 32'h10;
      for (int e = 0; e < 3 * p; e++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("held_listo", ob_listo, 32'((e % p) == lat_of(0)));
         check_eq("held_ocupado", ob_ocupado, 32'((e % p) != p - 1));
         if ((e % p) == lat_of(0)) check_eq("held_dato", ob_dato, 32'hDEADBEEF);
      end
      leer_t = 1'b0;
      model_commit(0, 1'b1, 1'b0, 32'h10, 32'h0);

      // reset during WAIT aborts the write
      do_req(0, 1'b0, 1'b1, 32'h0000_0020, 32'h11223344);
      @(negedge clk);
      sel = 0; escribir_t = 1'b1; direccion = 32'h20; palabra = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      escribir_t = 1'b0;
      check_eq("wait_busy", ob_ocupado, 32'd1);
      rst = 1'b1;
      #1;
      check_eq("abort_listo", listo_a, 32'd0);
      check_eq("abort_error", error_a, 32'd0);
      check_eq("abort_ocupado", ocupado_a, 32'd0);
      check_eq("abort_leer_dato", leer_dato_a, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      do_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
      check_eq("abort_kept_old", ob_dato, 32'h11223344);

      // reset during RESP drops listo immediately
      @(negedge clk);
      sel = 0; leer_t = 1'b1; direccion = 32'h20;
      @(posedge clk);
      @(negedge clk);
      leer_t = 1'b0;
      k = 1;
      while (ob_listo !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check_eq("resp_latency", k, lat_of(0) + 1);
      rst = 1'b1;
      #1;
      check_eq("resp_rst_listo", listo_a, 32'd0);
      check_eq("resp_rst_dato", leer_dato_a, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // zero-latency instance
      do_req(1, 1'b0, 1'b1, 32'h0000_0004, 32'hA5A5A5A5);
      do_req(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
      check_eq("lat0_read", ob_dato, 32'hA5A5A5A5);

      // randomized traffic on both instances
      for (int i = 0; i < 160; i++) begin
         int s, r, op;
         s  = int'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         op = int'($urandom_range(0, 4));
         if (r <= 6)      a = 32'($urandom_range(0, 15)) * 32'd4;
         else if (r == 7) a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
         else if (r == 8) a = 32'd1024 + 32'($urandom_range(0, 65535));
         else             a = 32'($urandom_range(0, 255)) * 32'd4;
         rd = (op <= 1) || (op == 4);
         wr = (op == 2) || (op == 3) || (op == 4);
         do_req(s, rd, wr, a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Wait-state data-memory responder serving the load/store side of the MIPS core. It accepts one read or write request at a time from the core: a byte address on `direccion`, write data on `palabra` and a strobe. It holds the request for a programmable number of wait cycles, then commits the write or returns read data on `leer_dato`, and signals completion with a one-cycle `listo` pulse. It sits between the core's memory-stage ports and the data storage, and replaces the zero-latency combinational memory for stall-path testing.

## Interface
- `ADDR_BITS`, default 8: word-address width. Storage depth is 2^ADDR_BITS words of 32 bits.
- `LATENCY`, default 2: number of wait cycles between request acceptance and response. Legal range is 0 to 15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `direccion` in 32: byte address of the request.
- `palabra` in 32: write data.
- `leer` in 1: read request strobe.
- `escribir` in 1: write request strobe.
- `leer_dato` out 32: read data, registered.
- `listo` out 1: completion pulse, one cycle wide.
- `error` out 1: request rejected; pulses together with `listo`.
- `ocupado` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, WAIT, RESP.
- **IDLE:**
  - A request is sampled when `leer` or `escribir` is high at a rising edge.
  - On sampling, the block captures `direccion`, `palabra` and the operation into internal registers.
  - Next state is WAIT with the 4-bit counter loaded to LATENCY-1. If LATENCY=0, next state is RESP and the commit happens on this same edge.
- **WAIT:**
  - The request inputs are ignored.
  - At each edge: if the counter is 0, go to RESP and commit; otherwise decrement the counter.
  - WAIT therefore lasts exactly LATENCY cycles.
- **Commit:**
  - Word index is the captured `direccion[ADDR_BITS+1:2]`.
  - Write: storage[index] <= captured `palabra`.
  - Read: `leer_dato` <= storage[index].
- **RESP:** `listo`=1 for exactly one cycle. The state returns to IDLE unconditionally. No request is sampled during RESP.
- **Error:** a request is in error if any of the following holds:
  - `direccion[1:0]` != 0 (misaligned);
  - `direccion[31:ADDR_BITS+2]` != 0 (out of range);
  - `leer` and `escribir` are both high at sampling.

  An errored request still runs the full WAIT/RESP sequence. At commit it performs no write and leaves `leer_dato` unchanged. In RESP, `error`=1 together with `listo`.
- **leer_dato hold:** the value persists until the next successful read commit.
- **Reset values:**
  - state = IDLE, counter = 0.
  - `listo`=0, `error`=0, `ocupado`=0, `leer_dato`=32'h0.
  - Storage contents are not reset.
- **Reset mid-operation:** asserting `rst` in WAIT aborts the request. No write is committed and `leer_dato` goes to 0. Reset asserted in RESP clears `listo` immediately.

## Timing
- A request sampled at edge N produces `listo` high in the cycle following edge N+LATENCY. Latency is LATENCY+1 cycles from the sampling edge.
- The write is visible in storage after edge N+LATENCY.
- Minimum spacing between sampled requests is LATENCY+2 cycles. A request held high continuously is re-sampled at the first edge in IDLE, so the core must drop its strobe on `listo`.
- `ocupado` is high from edge N to edge N+LATENCY+1, exclusive of the IDLE cycles.
- All outputs are registered. No combinational path from inputs to outputs.
- LATENCY=0: `listo` high in the cycle after the sampling edge; `ocupado` high for that single cycle.

## Test plan
- **Write then read (LATENCY=2):**
  - Write `direccion`=0x0000_0010, `palabra`=0xDEADBEEF: `listo` 3 cycles after sampling, `error`=0.
  - Read of the same address: `leer_dato`=0xDEADBEEF with `listo`.
- **Misaligned write:** write 0x0000_0012 with 0x12345678 -> `listo`=1 and `error`=1. A following read of 0x10 still returns 0xDEADBEEF.
- **Out of range (ADDR_BITS=8):** read 0x0000_0400 -> `error`=1 with `listo`; `leer_dato` holds its previous value.
- **Back-to-back held strobe:** `leer` held high for 10 cycles at 0x10 -> `listo` pulses exactly every 4 cycles; `ocupado` low exactly 1 cycle between requests.
- **Reset mid-operation:**
  - Write 0x20 with 0xCAFEF00D, assert `rst` in the first WAIT cycle: all outputs go to 0 at once.
  - A later read of 0x20 returns the pre-reset contents, not 0xCAFEF00D.
- **LATENCY=0 build:** write 0x4 with 0xA5A5A5A5, then read 0x4 -> each `listo` one cycle after sampling; `leer_dato`=0xA5A5A5A5.
